// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch squash, memory-stall freeze
// and a saturating count of inserted bubbles.
module id_ex_stage #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned REG_AW      = 4,
   parameter int unsigned ALUOP_W     = 4,
   parameter int unsigned CNT_W       = 16,
   parameter bit          ZERO_REG_EN = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_id_valid,
   input  logic [REG_AW-1:0]  i_id_rs1,
   input  logic [REG_AW-1:0]  i_id_rs2,
   input  logic               i_id_use_rs1,
   input  logic               i_id_use_rs2,
   input  logic [REG_AW-1:0]  i_id_rd,
   input  logic [DATA_W-1:0]  i_id_rs1_data,
   input  logic [DATA_W-1:0]  i_id_rs2_data,
   input  logic [DATA_W-1:0]  i_id_imm,
   input  logic [ALUOP_W-1:0] i_id_alu_op,
   input  logic               i_id_reg_wr,
   input  logic               i_id_mem_rd,
   input  logic               i_id_mem_wr,
   input  logic               i_id_wb_sel,
   input  logic               i_flush,
   input  logic               i_mem_stall,
   output logic               o_ex_valid,
   output logic [REG_AW-1:0]  o_ex_rs1,
   output logic [REG_AW-1:0]  o_ex_rs2,
   output logic [REG_AW-1:0]  o_ex_rd,
   output logic [DATA_W-1:0]  o_ex_rs1_data,
   output logic [DATA_W-1:0]  o_ex_rs2_data,
   output logic [DATA_W-1:0]  o_ex_imm,
   output logic [ALUOP_W-1:0] o_ex_alu_op,
   output logic               o_ex_reg_wr,
   output logic               o_ex_mem_rd,
   output logic               o_ex_mem_wr,
   output logic               o_ex_wb_sel,
   output logic               o_stall_id,
   output logic [CNT_W-1:0]   o_bubble_cnt
);

   logic               r_ex_valid;
   logic [REG_AW-1:0]  r_ex_rs1;
   logic [REG_AW-1:0]  r_ex_rs2;
   logic [REG_AW-1:0]  r_ex_rd;
   logic [DATA_W-1:0]  r_ex_rs1_data;
   logic [DATA_W-1:0]  r_ex_rs2_data;
   logic [DATA_W-1:0]  r_ex_imm;
   logic [ALUOP_W-1:0] r_ex_alu_op;
   logic               r_ex_reg_wr;
   logic               r_ex_mem_rd;
   logic               r_ex_mem_wr;
   logic               r_ex_wb_sel;
   logic [CNT_W-1:0]   r_bubble_cnt;

   logic               w_ex_valid_nxt;
   logic [REG_AW-1:0]  w_ex_rs1_nxt;
   logic [REG_AW-1:0]  w_ex_rs2_nxt;
   logic [REG_AW-1:0]  w_ex_rd_nxt;
   logic [DATA_W-1:0]  w_ex_rs1_data_nxt;
   logic [DATA_W-1:0]  w_ex_rs2_data_nxt;
   logic [DATA_W-1:0]  w_ex_imm_nxt;
   logic [ALUOP_W-1:0] w_ex_alu_op_nxt;
   logic               w_ex_reg_wr_nxt;
   logic               w_ex_mem_rd_nxt;
   logic               w_ex_mem_wr_nxt;
   logic               w_ex_wb_sel_nxt;
   logic [CNT_W-1:0]   w_bubble_cnt_nxt;

   logic               w_rs1_match;
   logic               w_rs2_match;
   logic               w_rd_ok;
   logic               w_lu_haz;
   logic               w_bubble;

   // Hazard only against a live load in EX; bubbles in EX can never stall ID.
   assign w_rs1_match = i_id_use_rs1 & (i_id_rs1 == r_ex_rd);
   assign w_rs2_match = i_id_use_rs2 & (i_id_rs2 == r_ex_rd);
   assign w_rd_ok     = ZERO_REG_EN ? (r_ex_rd != '0) : 1'b1;
   assign w_lu_haz    = r_ex_valid & r_ex_mem_rd & i_id_valid & (w_rs1_match | w_rs2_match) &
                        w_rd_ok;
   assign o_stall_id  = w_lu_haz & ~i_flush;
   assign w_bubble    = i_flush | w_lu_haz;

   always_comb begin
      w_ex_valid_nxt    = r_ex_valid;
      w_ex_rs1_nxt      = r_ex_rs1;
      w_ex_rs2_nxt      = r_ex_rs2;
      w_ex_rd_nxt       = r_ex_rd;
      w_ex_rs1_data_nxt = r_ex_rs1_data;
      w_ex_rs2_data_nxt = r_ex_rs2_data;
      w_ex_imm_nxt      = r_ex_imm;
      w_ex_alu_op_nxt   = r_ex_alu_op;
      w_ex_reg_wr_nxt   = r_ex_reg_wr;
      w_ex_mem_rd_nxt   = r_ex_mem_rd;
      w_ex_mem_wr_nxt   = r_ex_mem_wr;
      w_ex_wb_sel_nxt   = r_ex_wb_sel;
      w_bubble_cnt_nxt  = r_bubble_cnt;

      if (i_mem_stall) begin
         // Whole pipe frozen; a pending flush is honoured on the first unstalled edge.
      end else if (w_bubble) begin
         w_ex_valid_nxt    = 1'b0;
         w_ex_rs1_nxt      = '0;
         w_ex_rs2_nxt      = '0;
         w_ex_rd_nxt       = '0;
         w_ex_rs1_data_nxt = '0;
         w_ex_rs2_data_nxt = '0;
         w_ex_imm_nxt      = '0;
         w_ex_alu_op_nxt   = '0;
         w_ex_reg_wr_nxt   = 1'b0;
         w_ex_mem_rd_nxt   = 1'b0;
         w_ex_mem_wr_nxt   = 1'b0;
         w_ex_wb_sel_nxt   = 1'b0;
         if (!i_flush && (r_bubble_cnt != {CNT_W{1'b1}})) begin
            w_bubble_cnt_nxt = r_bubble_cnt + 1'b1;
         end
      end else begin
         w_ex_valid_nxt    = i_id_valid;
         w_ex_rs1_nxt      = i_id_rs1;
         w_ex_rs2_nxt      = i_id_rs2;
         w_ex_rd_nxt       = i_id_rd;
         w_ex_rs1_data_nxt = i_id_rs1_data;
         w_ex_rs2_data_nxt = i_id_rs2_data;
         w_ex_imm_nxt      = i_id_imm;
         w_ex_alu_op_nxt   = i_id_alu_op;
         w_ex_reg_wr_nxt   = i_id_reg_wr;
         w_ex_mem_rd_nxt   = i_id_mem_rd;
         w_ex_mem_wr_nxt   = i_id_mem_wr;
         w_ex_wb_sel_nxt   = i_id_wb_sel;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex_valid    <= 1'b0;
         r_ex_rs1      <= '0;
         r_ex_rs2      <= '0;
         r_ex_rd       <= '0;
         r_ex_rs1_data <= '0;
         r_ex_rs2_data <= '0;
         r_ex_imm      <= '0;
         r_ex_alu_op   <= '0;
         r_ex_reg_wr   <= 1'b0;
         r_ex_mem_rd   <= 1'b0;
         r_ex_mem_wr   <= 1'b0;
         r_ex_wb_sel   <= 1'b0;
         r_bubble_cnt  <= '0;
      end else begin
         r_ex_valid    <= w_ex_valid_nxt;
         r_ex_rs1      <= w_ex_rs1_nxt;
         r_ex_rs2      <= w_ex_rs2_nxt;
         r_ex_rd       <= w_ex_rd_nxt;
         r_ex_rs1_data <= w_ex_rs1_data_nxt;
         r_ex_rs2_data <= w_ex_rs2_data_nxt;
         r_ex_imm      <= w_ex_imm_nxt;
         r_ex_alu_op   <= w_ex_alu_op_nxt;
         r_ex_reg_wr   <= w_ex_reg_wr_nxt;
         r_ex_mem_rd   <= w_ex_mem_rd_nxt;
         r_ex_mem_wr   <= w_ex_mem_wr_nxt;
         r_ex_wb_sel   <= w_ex_wb_sel_nxt;
         r_bubble_cnt  <= w_bubble_cnt_nxt;
      end
   end

   assign o_ex_valid    = r_ex_valid;
   assign o_ex_rs1      = r_ex_rs1;
   assign o_ex_rs2      = r_ex_rs2;
   assign o_ex_rd       = r_ex_rd;
   assign o_ex_rs1_data = r_ex_rs1_data;
   assign o_ex_rs2_data = r_ex_rs2_data;
   assign o_ex_imm      = r_ex_imm;
   assign o_ex_alu_op   = r_ex_alu_op;
   // An invalid instruction loaded from ID must never write or touch memory.
   assign o_ex_reg_wr   = r_ex_reg_wr & r_ex_valid;
   assign o_ex_mem_rd   = r_ex_mem_rd & r_ex_valid;
   assign o_ex_mem_wr   = r_ex_mem_wr & r_ex_valid;
   assign o_ex_wb_sel   = r_ex_wb_sel;
   assign o_bubble_cnt  = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomised and directed bench for id_ex_stage against a behavioural model of what EX holds.
module tb_id_ex_stage;
   localparam int DW = 32;
   localparam int AW = 4;
   localparam int OW = 4;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          id_valid, id_use_rs1, id_use_rs2, id_reg_wr, id_mem_rd, id_mem_wr, id_wb_sel;
   logic [AW-1:0] id_rs1, id_rs2, id_rd;
   logic [DW-1:0] id_rs1_data, id_rs2_data, id_imm;
   logic [OW-1:0] id_alu_op;
   logic          flush, mem_stall;
   logic          ex_valid, ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_wb_sel, stall_id;
   logic [AW-1:0] ex_rs1, ex_rs2, ex_rd;
   logic [DW-1:0] ex_rs1_data, ex_rs2_data, ex_imm;
   logic [OW-1:0] ex_alu_op;
   logic [CW-1:0] bubble_cnt;

   int n_checks = 0;
   int n_fail = 0;

   // What EX should hold; control bits stored already qualified by validity.
   typedef struct {
      bit        valid;
      bit [AW-1:0] rs1, rs2, rd;
      bit [DW-1:0] d1, d2, imm;
      bit [OW-1:0] op;
      bit        reg_wr, mem_rd, mem_wr, wb;
   } ex_t;
   ex_t m;
   int  m_cnt;

   always #5 clk = ~clk;

   id_ex_stage #(
      .DATA_W(DW), .REG_AW(AW), .ALUOP_W(OW), .CNT_W(CW), .ZERO_REG_EN(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .i_id_valid(id_valid), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
      .i_id_use_rs1(id_use_rs1), .i_id_use_rs2(id_use_rs2), .i_id_rd(id_rd),
      .i_id_rs1_data(id_rs1_data), .i_id_rs2_data(id_rs2_data), .i_id_imm(id_imm),
      .i_id_alu_op(id_alu_op), .i_id_reg_wr(id_reg_wr), .i_id_mem_rd(id_mem_rd),
      .i_id_mem_wr(id_mem_wr), .i_id_wb_sel(id_wb_sel), .i_flush(flush),
      .i_mem_stall(mem_stall),
      .o_ex_valid(ex_valid), .o_ex_rs1(ex_rs1), .o_ex_rs2(ex_rs2), .o_ex_rd(ex_rd),
      .o_ex_rs1_data(ex_rs1_data), .o_ex_rs2_data(ex_rs2_data), .o_ex_imm(ex_imm),
      .o_ex_alu_op(ex_alu_op), .o_ex_reg_wr(ex_reg_wr), .o_ex_mem_rd(ex_mem_rd),
      .o_ex_mem_wr(ex_mem_wr), .o_ex_wb_sel(ex_wb_sel), .o_stall_id(stall_id),
      .o_bubble_cnt(bubble_cnt)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit model_haz();
      bit dep;
      dep = (id_use_rs1 && id_rs1 == m.rd) || (id_use_rs2 && id_rs2 == m.rd);
      return m.valid && m.mem_rd && id_valid && dep && (m.rd != 0);
   endfunction

   function automatic void model_reset();
      m = '{default: '0};
      m_cnt = 0;
   endfunction

   function automatic void model_edge();
      bit haz;
      haz = model_haz();
      if (mem_stall) return;
      if (flush || haz) begin
         m = '{default: '0};
         if (!flush && m_cnt < (1 << CW) - 1) m_cnt++;
      end else begin
         m.valid  = id_valid;
         m.rs1    = id_rs1;
         m.rs2    = id_rs2;
         m.rd     = id_rd;
         m.d1     = id_rs1_data;
         m.d2     = id_rs2_data;
         m.imm    = id_imm;
         m.op     = id_alu_op;
         m.reg_wr = id_valid & id_reg_wr;
         m.mem_rd = id_valid & id_mem_rd;
         m.mem_wr = id_valid & id_mem_wr;
         m.wb     = id_wb_sel;
      end
   endfunction

   task automatic compare_all(input string tag);
      check_eq({tag, ".valid"}, 64'(ex_valid), 64'(m.valid));
      check_eq({tag, ".rs1"}, 64'(ex_rs1), 64'(m.rs1));
      check_eq({tag, ".rs2"}, 64'(ex_rs2), 64'(m.rs2));
      check_eq({tag, ".rd"}, 64'(ex_rd), 64'(m.rd));
      check_eq({tag, ".d1"}, 64'(ex_rs1_data), 64'(m.d1));
      check_eq({tag, ".d2"}, 64'(ex_rs2_data), 64'(m.d2));
      check_eq({tag, ".imm"}, 64'(ex_imm), 64'(m.imm));
      check_eq({tag, ".op"}, 64'(ex_alu_op), 64'(m.op));
      check_eq({tag, ".reg_wr"}, 64'(ex_reg_wr), 64'(m.reg_wr));
      check_eq({tag, ".mem_rd"}, 64'(ex_mem_rd), 64'(m.mem_rd));
      check_eq({tag, ".mem_wr"}, 64'(ex_mem_wr), 64'(m.mem_wr));
      check_eq({tag, ".wb"}, 64'(ex_wb_sel), 64'(m.wb));
      check_eq({tag, ".cnt"}, 64'(bubble_cnt), 64'(m_cnt));
   endtask

   // Called just after a negedge with ID inputs already driven.
   task automatic cycle(input string tag);
      #1;
      check_eq({tag, ".stall_id"}, 64'(stall_id), 64'(model_haz() && !flush));
      @(posedge clk);
      model_edge();
      #1;
      compare_all(tag);
      @(negedge clk);
   endtask

   task automatic set_instr(input bit v, input bit [AW-1:0] rs1, input bit u1,
                            input bit [AW-1:0] rs2, input bit u2, input bit [AW-1:0] rd,
                            input bit wr, input bit ld, input bit st);
      id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
      id_rd = rd; id_reg_wr = wr; id_mem_rd = ld; id_mem_wr = st; id_wb_sel = ld;
      id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
      id_alu_op = OW'($urandom);
   endtask

   task automatic rand_inputs();
      set_instr(($urandom_range(9) < 8), AW'($urandom_range(3)), 1'($urandom),
                AW'($urandom_range(3)), 1'($urandom), AW'($urandom_range(3)),
                1'($urandom), ($urandom_range(9) < 4), ($urandom_range(9) < 2));
      id_wb_sel = 1'($urandom);
      flush     = ($urandom_range(9) == 0);
      mem_stall = ($urandom_range(99) < 15);
   endtask

   initial begin
      model_reset();
      set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
      flush = 0; mem_stall = 0;
      @(negedge clk); @(negedge clk);
      compare_all("reset");
      rst_n = 1'b1;

      // Load r3 followed by a dependent add: one bubble, then the add enters EX.
      set_instr(1, 0, 0, 0, 0, 3, 1, 1, 0);
      cycle("ld_r3");
      set_instr(1, 3, 1, 1, 1, 5, 1, 0, 0);
      #1 check_eq("lu.stall", 64'(stall_id), 64'd1);
      cycle("lu.bubble");
      check_eq("lu.ex_valid", 64'(ex_valid), 64'd0);
      check_eq("lu.ex_mem_rd", 64'(ex_mem_rd), 64'd0);
      check_eq("lu.cnt", 64'(bubble_cnt), 64'd1);
      cycle("lu.add");
      check_eq("lu.add_rd", 64'(ex_rd), 64'd5);
      check_eq("lu.add_valid", 64'(ex_valid), 64'd1);

      // Hazard coinciding with flush: no stall, bubble, count unchanged.
      set_instr(1, 0, 0, 0, 0, 3, 1, 1, 0);
      cycle("ld_r3b");
      set_instr(1, 3, 1, 0, 0, 6, 1, 0, 0);
      flush = 1;
      #1 check_eq("flush.stall", 64'(stall_id), 64'd0);
      cycle("flush");
      check_eq("flush.cnt", 64'(bubble_cnt), 64'd1);
      check_eq("flush.valid", 64'(ex_valid), 64'd0);
      flush = 0;

      // Memory stall with changing ID fields, then release captures the new fields.
      set_instr(1, 1, 1, 2, 1, 7, 1, 0, 0);
      cycle("pre_stall");
      mem_stall = 1;
      for (int i = 0; i < 3; i++) begin
         set_instr(1, AW'($urandom), 1, AW'($urandom), 1, AW'($urandom), 1, 0, 1);
         cycle("mstall");
         check_eq("mstall.rd_hold", 64'(ex_rd), 64'd7);
      end
      mem_stall = 0;
      set_instr(1, 2, 1, 1, 0, 9, 1, 0, 0);
      cycle("mstall_rel");
      check_eq("mstall_rel.rd", 64'(ex_rd), 64'd9);

      // Load writing r0 never creates a hazard.
      set_instr(1, 0, 0, 0, 0, 0, 1, 1, 0);
      cycle("ld_r0");
      set_instr(1, 0, 1, 0, 1, 4, 1, 0, 0);
      #1 check_eq("r0.stall", 64'(stall_id), 64'd0);
      cycle("r0.use");
      check_eq("r0.valid", 64'(ex_valid), 64'd1);

      // Randomised traffic with an asynchronous reset mid-stream.
      for (int i = 0; i < 2000; i++) begin
         if (i == 1000) begin
            #2 rst_n = 1'b0;
            model_reset();
            #1 compare_all("async_rst");
            @(negedge clk);
            rst_n = 1'b1;
         end
         rand_inputs();
         cycle("rand");
      end

      // 17 load-use events saturate a 4-bit counter at 15.
      flush = 0; mem_stall = 0;
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 17; i++) begin
         set_instr(1, 0, 0, 0, 0, 2, 1, 1, 0);
         cycle("sat.ld");
         set_instr(1, 1, 0, 2, 1, 3, 1, 0, 0);
         cycle("sat.use");
      end
      check_eq("sat.cnt", 64'(bubble_cnt), 64'd15);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
